alu_exec: RTL and testbench
===========================

# alu_exec

Execute stage that consumes the 4-bit ALU control code produced by the ALU decoder and performs the operation on two WIDTH-bit operands. Operands and control are captured through a valid/ready handshake. Results and flags are held in output registers until the downstream writeback stage accepts them. Shifts run iteratively, one bit per cycle; all other operations finish in one cycle.

## Interface
Parameters:
- WIDTH, 8, operand/result width; must be a power of two ≥ 2
- SHW, $clog2(WIDTH), width of shift amount taken from b

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream offers an operation
- in_ready  out  1  block can accept; high only in IDLE
- alu_control  in  4  operation code from ALU decoder
- a  in  WIDTH  operand A (shift source)
- b  in  WIDTH  operand B; b[SHW-1:0] is shift amount
- out_valid  out  1  result/flags valid; high only in DONE
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- carry  out  1  carry/borrow/shifted-out bit

## Operation
- Codes: 0000 add a+b; 0001 sub a−b; 0010 a&b; 0011 a|b; 1000 a^b; 0101 {0…,&a}; 0110 {0…,|a}; 0100 pass b; 0111 a<<n; 1001 a>>n (logical); any other code behaves as pass b.
- Carry rules:
  - add: carry out of bit WIDTH−1.
  - sub: borrow, i.e. 1 iff a<b unsigned.
  - shift: last bit shifted out; 0 if n=0.
  - all other ops: 0.
- Arithmetic is modulo 2^WIDTH.
- zero is computed from the final result in every case.
- FSM states IDLE, SHIFT, DONE:
  - IDLE: in_ready=1. On in_valid the inputs are captured.
    - Shift op with n≠0: load work register with a, count with n, go SHIFT.
    - Any other op, or n=0: compute and register result/flags, go DONE.
  - SHIFT: each cycle shift work register one bit in the op direction, capture the outgoing bit into carry, decrement count. When count reaches 0, load result and zero, then go DONE.
  - DONE: out_valid=1; result/flags stable. On out_ready go IDLE.
- in_valid outside IDLE is ignored; upstream must hold its offer.
- No bypass from DONE to accept: a new op is accepted no earlier than the cycle after out_ready handshake.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, zero=0, carry=0, count=0.
- Reset asserted in any state, including mid-SHIFT or DONE, aborts the operation and restores the reset values on the next edge. The pending result is discarded.
- Non-shift latency: accept at edge k → out_valid high after edge k+1.
- Shift by n≥1 (iterative): out_valid high after edge k+n+1.
- out_valid stays high with stable result until out_ready is sampled high. Holding out_ready=1 gives a 2-cycle minimum per-op throughput.

## Configuration
- ALU_BARREL_SHIFT_EN defined: shifts are computed combinationally in IDLE like every other op, with latency 1 for all codes. The SHIFT state and counter are not built. Carry is bit a[WIDTH−n] for left or a[n−1] for right, and 0 for n=0.
- ALU_BARREL_SHIFT_EN undefined: iterative shifting as described above.

## Structure
- Package alu_pkg holds:
  - localparams for all 4-bit ALU control codes, shared with the ALU decoder;
  - the FSM state enum.
- Sub-module alu_core: purely combinational single-cycle ops (add, sub, logic, reductions, pass, and barrel shift when enabled), producing result and carry.
- alu_exec owns the handshake, FSM, shift counter and output registers.

## Test plan
- Reset, then idle: in_ready=1, out_valid=0, result=0, zero=0, carry=0.
- add a=0xF0, b=0x20 → after 1 cycle: result=0x10, carry=1, zero=0. Hold out_ready=0 for 3 cycles: outputs stable and in_ready=0.
- sub a=0x05, b=0x05 → result=0x00, zero=1, carry=0. Then sub a=0x03, b=0x05 → result=0xFE, carry=1.
- shl a=0x81, b=3 → out_valid after 4 cycles (1 with ALU_BARREL_SHIFT_EN), result=0x08, carry=0. shr a=0x81, b=1 → result=0x40, carry=1.
- Reductions and fallback: code 0101 with a=0xFF → result=0x01; code 0110 with a=0x00 → result=0x00, zero=1; code 1111 with b=0x5A → result=0x5A.
- Assert reset during the 2nd SHIFT cycle of shl by 5 → next cycle in IDLE with all reset values. A following add 1+1 yields 0x02.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control codes (common with the ALU decoder) and the execute-stage FSM states.
// Optional build macro: ALU_BARREL_SHIFT_EN selects single-cycle barrel shifts.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_PASSB = 4'b0100;
    localparam logic [3:0] ALU_RAND  = 4'b0101;
    localparam logic [3:0] ALU_ROR   = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_XOR   = 4'b1000;
    localparam logic [3:0] ALU_SRL   = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU operations producing result and carry/borrow.
// With ALU_BARREL_SHIFT_EN defined, shifts are done here as well; otherwise shift codes return a unchanged.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    // Top bit of the widened difference is the borrow, i.e. a < b unsigned.
    assign diff = {1'b0, a} - {1'b0, b};

`ifdef ALU_BARREL_SHIFT_EN
    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt;
    logic [WIDTH:0] shl_ext;
    logic [WIDTH:0] shr_ext;

    assign shamt = b[SHW-1:0];
    // The extra guard bit catches the last bit shifted out, and stays 0 for n=0.
    assign shl_ext = {1'b0, a} << shamt;
    assign shr_ext = {a, 1'b0} >> shamt;
`endif

    always_comb begin
        result = b;
        carry  = 1'b0;
        case (alu_control)
            ALU_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            ALU_SUB: begin
                result = diff[WIDTH-1:0];
                carry  = diff[WIDTH];
            end
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_RAND:  result = {{(WIDTH-1){1'b0}}, &a};
            ALU_ROR:   result = {{(WIDTH-1){1'b0}}, |a};
            ALU_PASSB: result = b;
`ifdef ALU_BARREL_SHIFT_EN
            ALU_SLL: begin
                result = shl_ext[WIDTH-1:0];
                carry  = shl_ext[WIDTH];
            end
            ALU_SRL: begin
                result = shr_ext[WIDTH:1];
                carry  = shr_ext[0];
            end
`else
            ALU_SLL, ALU_SRL: result = a;
`endif
            default: result = b;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: valid/ready capture, iterative shifter FSM and registered result/flags.
// Optional build macro: ALU_BARREL_SHIFT_EN removes the SHIFT state and does every op in one cycle.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
// in_ready is high only in IDLE; out_valid is high only in DONE, where result/zero/carry
// are held stable until out_ready is sampled high. Offers made outside IDLE are ignored.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic [1:0]       state_dbg
);

    alu_state_t     state;
    alu_state_t     state_next;
    logic [WIDTH-1:0] core_result;
    logic             core_carry;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .alu_control (alu_control),
        .a           (a),
        .b           (b),
        .result      (core_result),
        .carry       (core_carry)
    );

`ifndef ALU_BARREL_SHIFT_EN
    logic [SHW-1:0]   shamt;
    logic             start_shift;
    logic [SHW-1:0]   count;
    logic [WIDTH-1:0] work;
    logic             shift_left;
    logic [WIDTH-1:0] work_shifted;
    logic             shifted_out;

    assign shamt       = b[SHW-1:0];
    assign start_shift = ((alu_control == ALU_SLL) || (alu_control == ALU_SRL))
                         && (shamt != '0);

    always_comb begin
        work_shifted = shift_left ? (work << 1) : (work >> 1);
        shifted_out  = shift_left ? work[WIDTH-1] : work[0];
    end
`endif

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef ALU_BARREL_SHIFT_EN
                    state_next = ST_DONE;
`else
                    state_next = start_shift ? ST_SHIFT : ST_DONE;
`endif
                end
            end
`ifndef ALU_BARREL_SHIFT_EN
            ST_SHIFT: begin
                if (count == SHW'(1)) state_next = ST_DONE;
            end
`endif
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            zero   <= 1'b0;
            carry  <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            count      <= '0;
            work       <= '0;
            shift_left <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
`ifndef ALU_BARREL_SHIFT_EN
                        if (start_shift) begin
                            work       <= a;
                            count      <= shamt;
                            shift_left <= (alu_control == ALU_SLL);
                        end else
`endif
                        begin
                            result <= core_result;
                            zero   <= (core_result == '0);
                            carry  <= core_carry;
                        end
                    end
                end
`ifndef ALU_BARREL_SHIFT_EN
                // carry tracks the most recent outgoing bit; result only updates at the end.
                ST_SHIFT: begin
                    work  <= work_shifted;
                    carry <= shifted_out;
                    count <= count - SHW'(1);
                    if (count == SHW'(1)) begin
                        result <= work_shifted;
                        zero   <= (work_shifted == '0);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec with hand-computed expected values.
module tb_alu_exec;
    import alu_pkg::*;

    localparam int WIDTH = 8;

`ifdef ALU_BARREL_SHIFT_EN
    localparam int SHL3_LAT = 1;
`else
    localparam int SHL3_LAT = 4;
`endif

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic [1:0]       state_dbg;

    int total = 0;
    int bad   = 0;

    alu_exec #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .carry       (carry),
        .state_dbg   (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one op for a single accepting edge, then measure edges until out_valid.
    task automatic issue(input logic [3:0] code, input logic [7:0] av, input logic [7:0] bv,
                         output int lat);
        check("in_ready_before_issue", 32'(in_ready), 32'd1);
        alu_control = code;
        a           = av;
        b           = bv;
        in_valid    = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_after_accept", 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [3:0] code, input logic [7:0] av,
                          input logic [7:0] bv, input logic [7:0] exp_res, input logic exp_z,
                          input logic exp_c, input int exp_lat);
        int lat;
        issue(code, av, bv, lat);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_zero"}, 32'(zero), 32'(exp_z));
        check({tag, "_carry"}, 32'(carry), 32'(exp_c));
        accept();
    endtask

    initial begin
        int lat;
        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        alu_control = 4'h0;
        a           = '0;
        b           = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_zero", 32'(zero), 32'd0);
        check("reset_carry", 32'(carry), 32'd0);
        check("reset_state", 32'(state_dbg), 32'(ST_IDLE));

        // add with carry out, then hold downstream off for three cycles
        issue(ALU_ADD, 8'hF0, 8'h20, lat);
        check("add_latency", 32'(lat), 32'd1);
        for (int i = 0; i < 3; i++) begin
            // a competing offer while busy must be ignored
            alu_control = ALU_PASSB;
            b           = 8'h77;
            in_valid    = 1'b1;
            check("add_hold_out_valid", 32'(out_valid), 32'd1);
            check("add_hold_in_ready", 32'(in_ready), 32'd0);
            check("add_hold_result", 32'(result), 32'h10);
            check("add_hold_carry", 32'(carry), 32'd1);
            check("add_hold_zero", 32'(zero), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        accept();

        run_op("sub_eq", ALU_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1);
        run_op("sub_borrow", ALU_SUB, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1, 1);
        run_op("and", ALU_AND, 8'hCC, 8'hAA, 8'h88, 1'b0, 1'b0, 1);
        run_op("or", ALU_OR, 8'hC0, 8'h0A, 8'hCA, 1'b0, 1'b0, 1);
        run_op("xor", ALU_XOR, 8'hF0, 8'hFF, 8'h0F, 1'b0, 1'b0, 1);
        run_op("shl3", ALU_SLL, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, SHL3_LAT);
        run_op("shr1", ALU_SRL, 8'h81, 8'h01, 8'h40, 1'b0, 1'b1, 2 - (SHL3_LAT == 1 ? 1 : 0));
        run_op("shl0", ALU_SLL, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1);
        run_op("rand", ALU_RAND, 8'hFF, 8'h00, 8'h01, 1'b0, 1'b0, 1);
        run_op("ror", ALU_ROR, 8'h00, 8'h33, 8'h00, 1'b1, 1'b0, 1);
        run_op("fallback", 4'b1111, 8'h12, 8'h5A, 8'h5A, 1'b0, 1'b0, 1);

        // reset during the second SHIFT cycle of a shift by 5
        alu_control = ALU_SLL;
        a           = 8'hFF;
        b           = 8'h05;
        in_valid    = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_zero", 32'(zero), 32'd0);
        check("abort_carry", 32'(carry), 32'd0);
        check("abort_state", 32'(state_dbg), 32'(ST_IDLE));

        run_op("add_after_abort", ALU_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
